// File: rtl/seq_detect_1011.sv
// Serial "1011" pattern detector with a registered match pulse and a saturating match counter.
// Define SEQ_OVERLAP_EN to let the trailing "1" of one match begin the next match.

module seq_detect_1011 #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             count_clr,
  output logic             detect,
  output logic [CNT_W-1:0] det_count,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StG1   = 3'd1,
    StG10  = 3'd2,
    StG101 = 3'd3,
    StHit  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e state_q, state_d;
  logic   match;

  // A match completes on the valid "1" that arrives while in G101.
  assign match = din_valid && din && (state_q == StG101);

  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      case (state_q)
        StIdle:  state_d = din ? StG1   : StIdle;
        StG1:    state_d = din ? StG1   : StG10;
        StG10:   state_d = din ? StG101 : StIdle;
        StG101:  state_d = din ? StHit  : StG10;
`ifdef SEQ_OVERLAP_EN
        StHit:   state_d = din ? StG1   : StG10;
`else
        StHit:   state_d = din ? StG1   : StIdle;
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      detect    <= 1'b0;
      det_count <= '0;
    end else begin
      state_q <= state_d;
      detect  <= match;
      // Clear wins over a coincident increment.
      if (count_clr) begin
        det_count <= '0;
      end else if (match && (det_count != CntMax)) begin
        det_count <= det_count + CntOne;
      end
    end
  end

  assign state = state_q;

  detect_in_hit_a : assert property (@(posedge clk) disable iff (rst)
    detect |-> (state_q == StHit));

  detect_single_a : assert property (@(posedge clk) disable iff (rst)
    detect |=> !detect);

endmodule

// File: tb/tb_seq_detect_1011.sv
// Directed self-checking bench for seq_detect_1011 (counter built at CNT_W=2 so saturation is
// reachable); expectations follow SEQ_OVERLAP_EN when it is defined.

module tb_seq_detect_1011;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       count_clr;
  logic       detect;
  logic [1:0] det_count;
  logic [2:0] state;

  int n_checks;
  int n_fail;
  int pulses;

  seq_detect_1011 #(
    .CNT_W(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_valid(din_valid),
    .count_clr(count_clr),
    .detect   (detect),
    .det_count(det_count),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one bit between edges, then sample just after the rising edge.
  task automatic step(input logic b, input logic v, input logic clr);
    @(negedge clk);
    din       = b;
    din_valid = v;
    count_clr = clr;
    @(posedge clk);
    #1;
    if (detect === 1'b1) pulses++;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  logic [3:0]  pat;
  logic [6:0]  ovl;
  logic [11:0] st_exp;
  logic [3:0]  det_exp;
  int          exp_pulses;
  int          exp_cnt;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    pulses    = 0;
    rst       = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    count_clr = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("reset_state", 32'(state), 0);
    check("reset_detect", 32'(detect), 0);
    check("reset_count", 32'(det_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic 1,0,1,1 match.
    pat     = 4'b1011;
    st_exp  = {3'd1, 3'd2, 3'd3, 3'd4};
    det_exp = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step(pat[3-i], 1'b1, 1'b0);
      check($sformatf("basic_state_%0d", i), 32'(state), 32'(st_exp[11-3*i -: 3]));
      check($sformatf("basic_detect_%0d", i), 32'(detect), 32'(det_exp[3-i]));
    end
    check("basic_count", 32'(det_count), 1);

    // Hold in HIT with din_valid low: no re-assertion.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("hold_detect_%0d", i), 32'(detect), 0);
      check($sformatf("hold_state_%0d", i), 32'(state), 4);
    end
    check("hold_pulses", 32'(pulses), 1);
    check("hold_count", 32'(det_count), 1);

    // Overlap stream 1,0,1,1,0,1,1.
    pulse_rst();
    check("ovl_rst_state", 32'(state), 0);
    pulses = 0;
    ovl    = 7'b1011011;
    for (int i = 0; i < 7; i++) step(ovl[6-i], 1'b1, 1'b0);
`ifdef SEQ_OVERLAP_EN
    exp_pulses = 2;
    check("ovl_state", 32'(state), 4);
`else
    exp_pulses = 1;
    check("ovl_state", 32'(state), 1);
`endif
    check("ovl_pulses", 32'(pulses), 32'(exp_pulses));
    check("ovl_count", 32'(det_count), 32'(exp_pulses));

    // Reset in the middle of a partial match.
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("mid_pre_state", 32'(state), 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_async_state", 32'(state), 0);
    check("mid_async_detect", 32'(detect), 0);
    check("mid_async_count", 32'(det_count), 0);
    #2 rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("mid_post_detect", 32'(detect), 0);
    check("mid_post_state", 32'(state), 1);
    check("mid_post_count", 32'(det_count), 0);

    // Saturation at 3 with CNT_W=2, then clear racing a 6th match.
    pulse_rst();
    pulses = 0;
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) step(pat[3-i], 1'b1, 1'b0);
      exp_cnt = (m + 1 > 3) ? 3 : m + 1;
      check($sformatf("sat_detect_%0d", m), 32'(detect), 1);
      check($sformatf("sat_count_%0d", m), 32'(det_count), 32'(exp_cnt));
    end
    check("sat_pulses", 32'(pulses), 5);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("clr_detect", 32'(detect), 1);
    check("clr_count", 32'(det_count), 0);
    check("clr_state", 32'(state), 4);
    step(1'b0, 1'b0, 1'b0);
    check("clr_after_detect", 32'(detect), 0);
    check("clr_after_count", 32'(det_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
